// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the write- and read-side controllers of the
// dual-clock Gray-pointer FIFO.
//   fifo_depth(aw)  : number of entries for an address width (2**aw)
//   bin2gray/gray2bin : pointer code conversions, usable at any width <= 32
//   SYNC_STAGES_MIN : fewest flops allowed in a pointer synchroniser
package fifo_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Both conversions act on a zero-extended value, so the caller picks the
    // width by casting the argument in and the result back out.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync: STAGES-deep flop chain carrying a Gray pointer into another
// clock domain. Synchronous active-high reset flushes every stage.
//   i_clk : destination-domain clock
//   i_rst : synchronous reset, active-high
//   i_d   : pointer from the other domain (unsynchronised)
//   o_q   : last stage of the chain
module fifo_ptr_sync
    import fifo_pkg::*;
#(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Requests below the minimum are raised to it rather than weakening the chain.
    localparam int unsigned N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

    logic [W-1:0] r_stage [N];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < N; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[N-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the dual-clock Gray-pointer FIFO.
// Holds binary/Gray write pointers and memory address, synchronises the read
// Gray pointer, and registers full / almost-full / level / overflow status.
//   wr_clk_wr, wr_rst_wr : clock, synchronous active-high reset
//   wr_inc_wr            : write request
//   rd_gptr_wr           : read-domain Gray pointer (unsynchronised)
//   wr_en_mem_wr         : memory write strobe (combinational)
//   wr_addr_wr           : memory write address
//   wr_ptr_wr            : Gray write pointer to the read domain
//   full_wr, almost_full_wr, level_wr, overflow_wr : status
// Build option FIFO_WR_OVF_STICKY_EN: overflow_wr latches until reset instead
// of pulsing for one cycle after each dropped write.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int AF_LEVEL    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wr_clk_wr,
    input  logic              wr_rst_wr,
    input  logic              wr_inc_wr,
    input  logic [ADDR_W:0]   rd_gptr_wr,
    output logic              wr_en_mem_wr,
    output logic [ADDR_W-1:0] wr_addr_wr,
    output logic [ADDR_W:0]   wr_ptr_wr,
    output logic              full_wr,
    output logic              almost_full_wr,
    output logic [ADDR_W:0]   level_wr,
    output logic              overflow_wr
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = int'(fifo_depth(ADDR_W));
    localparam int AF_EFF = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
    localparam logic [PW-1:0] AF_THR = PW'(AF_EFF);
    // Full when the Gray write pointer equals the read pointer with its top two bits inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

    logic [PW-1:0]     r_bin;
    logic [PW-1:0]     r_gptr;
    logic [ADDR_W-1:0] r_addr;
    logic [PW-1:0]     r_level;
    logic              r_full;
    logic              r_af;
    logic              r_ovf;

    logic              w_accept;
    logic              w_drop;
    logic [PW-1:0]     w_sq_rptr;
    logic [PW-1:0]     w_bin_next;
    logic [PW-1:0]     w_gptr_next;
    logic [PW-1:0]     w_rptr_bin;
    logic [PW-1:0]     w_level_next;

    fifo_ptr_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk (wr_clk_wr),
        .i_rst (wr_rst_wr),
        .i_d   (rd_gptr_wr),
        .o_q   (w_sq_rptr)
    );

    assign w_accept = wr_inc_wr & ~r_full;
    assign w_drop   = wr_inc_wr &  r_full;

    always_comb begin
        w_bin_next   = w_accept ? (r_bin + PW'(1)) : r_bin;
        w_gptr_next  = PW'(bin2gray(32'(w_bin_next)));
        w_rptr_bin   = PW'(gray2bin(32'(w_sq_rptr)));
        w_level_next = w_bin_next - w_rptr_bin;
    end

    always_ff @(posedge wr_clk_wr) begin
        if (wr_rst_wr) begin
            r_bin   <= '0;
            r_gptr  <= '0;
            r_addr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_bin   <= w_bin_next;
            r_gptr  <= w_gptr_next;
            r_addr  <= w_bin_next[ADDR_W-1:0];
            r_level <= w_level_next;
            r_full  <= (w_gptr_next == (w_sq_rptr ^ FULL_MASK));
            r_af    <= (w_level_next >= AF_THR);
`ifdef FIFO_WR_OVF_STICKY_EN
            r_ovf   <= r_ovf | w_drop;
`else
            r_ovf   <= w_drop;
`endif
        end
    end

    assign wr_en_mem_wr   = w_accept;
    assign wr_addr_wr     = r_addr;
    assign wr_ptr_wr      = r_gptr;
    assign full_wr        = r_full;
    assign almost_full_wr = r_af;
    assign level_wr       = r_level;
    assign overflow_wr    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at ADDR_W=3, AF_LEVEL=6, SYNC_STAGES=2.
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_OVF_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       inc;
    logic [3:0] rg;
    logic       en;
    logic [2:0] addr;
    logic [3:0] ptr;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_wr_ctrl #(
        .ADDR_W      (3),
        .AF_LEVEL    (6),
        .SYNC_STAGES (2)
    ) dut (
        .wr_clk_wr      (clk),
        .wr_rst_wr      (rst),
        .wr_inc_wr      (inc),
        .rd_gptr_wr     (rg),
        .wr_en_mem_wr   (en),
        .wr_addr_wr     (addr),
        .wr_ptr_wr      (ptr),
        .full_wr        (full),
        .almost_full_wr (af),
        .level_wr       (lvl),
        .overflow_wr    (ovf)
    );

    typedef struct {
        logic       rst;
        logic       inc;
        logic [3:0] rg;
        logic       en;
        logic [2:0] addr;
        logic [3:0] ptr;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic i, input logic [3:0] g,
                       input logic e, input logic [2:0] a, input logic [3:0] p,
                       input logic f, input logic al, input logic [3:0] l,
                       input logic o);
        vec_t v;
        v.rst = r; v.inc = i; v.rg = g; v.en = e; v.addr = a; v.ptr = p;
        v.full = f; v.af = al; v.lvl = l; v.ovf = o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = 4'(v % 16);
        return b ^ (b >> 1);
    endfunction

    initial begin
        rst = 1'b1; inc = 1'b0; rg = '0;

        //   rst inc rg   en addr ptr   full af lvl   ovf
        add(1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'd0, 0);          // reset
        add(1, 1, 4'h0, 1, 0, 4'h0, 0, 0, 4'd0, 0);          // reset wins over write
        add(0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'd0, 0);          // released, idle
        add(0, 1, 4'h0, 1, 1, 4'h1, 0, 0, 4'd1, 0);          // 8 writes
        add(0, 1, 4'h0, 1, 2, 4'h3, 0, 0, 4'd2, 0);
        add(0, 1, 4'h0, 1, 3, 4'h2, 0, 0, 4'd3, 0);
        add(0, 1, 4'h0, 1, 4, 4'h6, 0, 0, 4'd4, 0);
        add(0, 1, 4'h0, 1, 5, 4'h7, 0, 0, 4'd5, 0);
        add(0, 1, 4'h0, 1, 6, 4'h5, 0, 1, 4'd6, 0);
        add(0, 1, 4'h0, 1, 7, 4'h4, 0, 1, 4'd7, 0);
        add(0, 1, 4'h0, 1, 0, 4'hC, 1, 1, 4'd8, 0);          // full
        add(0, 1, 4'h0, 0, 0, 4'hC, 1, 1, 4'd8, 1);          // dropped writes
        add(0, 1, 4'h0, 0, 0, 4'hC, 1, 1, 4'd8, 1);
        add(0, 0, 4'h0, 0, 0, 4'hC, 1, 1, 4'd8, STICKY);
        add(0, 0, 4'h1, 0, 0, 4'hC, 1, 1, 4'd8, STICKY);     // read pointer moves
        add(0, 0, 4'h1, 0, 0, 4'hC, 1, 1, 4'd8, STICKY);
        add(0, 0, 4'h1, 0, 0, 4'hC, 0, 1, 4'd7, STICKY);     // 3rd edge: released
        add(0, 1, 4'h1, 1, 1, 4'hD, 1, 1, 4'd8, STICKY);     // refill
        add(0, 1, 4'h1, 0, 1, 4'hD, 1, 1, 4'd8, 1);          // drop again
        add(1, 1, 4'h1, 0, 0, 4'h0, 0, 0, 4'd0, 0);          // reset while full
        add(0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'd0, 0);          // sync flushed: level 0

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; inc = vecs[k].inc; rg = vecs[k].rg;
            #1;
            chk("wr_en", k, 32'(en), 32'(vecs[k].en));
            @(posedge clk);
            #1;
            chk("addr",  k, 32'(addr), 32'(vecs[k].addr));
            chk("ptr",   k, 32'(ptr),  32'(vecs[k].ptr));
            chk("full",  k, 32'(full), 32'(vecs[k].full));
            chk("afull", k, 32'(af),   32'(vecs[k].af));
            chk("level", k, 32'(lvl),  32'(vecs[k].lvl));
            chk("ovf",   k, 32'(ovf),  32'(vecs[k].ovf));
        end

        // Streaming with the read pointer trailing by one: pointers wrap, level settles at 4.
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            rst = 1'b0; inc = 1'b1;
            rg  = (j >= 1) ? gray4(j - 1) : 4'h0;
            #1;
            chk("stream_en", 100 + j, 32'(en), 32'd1);
            @(posedge clk);
            #1;
            chk("stream_addr",  100 + j, 32'(addr), 32'((j + 1) % 8));
            chk("stream_ptr",   100 + j, 32'(ptr),  32'(gray4(j + 1)));
            chk("stream_full",  100 + j, 32'(full), 32'd0);
            chk("stream_afull", 100 + j, 32'(af),   32'd0);
            chk("stream_level", 100 + j, 32'(lvl),  32'((j < 3) ? (j + 1) : 4));
        end

        @(negedge clk);
        inc = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Parametrised write-side controller for the dual-clock Gray-pointer FIFO between the UART core and the host side; it succeeds the fixed 8-entry write-pointer block.
- Holds the binary and Gray write pointers and the memory write address.
- Includes its own multi-stage synchroniser for the read-domain Gray pointer.
- Produces registered full, almost-full, fill-level and overflow status, all in the write clock domain.

Parameters:
- ADDR_W, 3: memory address width; DEPTH = 2**ADDR_W entries; pointers are ADDR_W+1 bits.
- AF_LEVEL, 6: almost_full_wr asserts when level_wr >= AF_LEVEL; legal range 1..DEPTH.
- SYNC_STAGES, 2: flops in the read-pointer synchroniser; minimum 2.

Ports:
- wr_clk_wr  in  1  write-domain clock; the only clock.
- wr_rst_wr  in  1  reset, synchronous, active-high.
- wr_inc_wr  in  1  write request for this cycle.
- rd_gptr_wr  in  ADDR_W+1  read-domain Gray pointer, unsynchronised.
- wr_en_mem_wr  out  1  memory write strobe = wr_inc_wr && !full_wr (combinational).
- wr_addr_wr  out  ADDR_W  memory write address, registered.
- wr_ptr_wr  out  ADDR_W+1  Gray write pointer to the read domain, registered.
- full_wr  out  1  FIFO full, registered.
- almost_full_wr  out  1  level at or above AF_LEVEL, registered.
- level_wr  out  ADDR_W+1  entries occupied, 0..DEPTH, registered.
- overflow_wr  out  1  write attempted while full.

Behaviour:
Reset:
- wr_rst_wr=1 sampled at a clock edge clears all of the following; wr_rst_wr has priority over everything:
  - binary pointer, wr_ptr_wr, wr_addr_wr;
  - every synchroniser stage;
  - full_wr, almost_full_wr, level_wr, overflow_wr.

Synchroniser:
- rd_gptr_wr passes through SYNC_STAGES flops; sq_rptr is the last stage.
- Status logic uses only sq_rptr, never the raw input.

Write acceptance:
- A write is accepted when wr_inc_wr=1 and full_wr=0 in the same cycle.
- On acceptance, memory writes at the current wr_addr_wr, and at the edge:
  - bin_next = bin + 1, modulo 2**(ADDR_W+1), wrapping silently;
  - wr_addr_wr <= bin_next[ADDR_W-1:0];
  - wr_ptr_wr <= bin_next ^ (bin_next >> 1).
- Otherwise the pointers hold.
- Outputs update exactly one cycle after acceptance; back-to-back writes every cycle are legal.

Status, registered every cycle from bin_next and the current sq_rptr:
- full_wr <= (gray(bin_next) == {~sq_rptr[ADDR_W:ADDR_W-1], sq_rptr[ADDR_W-2:0]}).
- level_wr <= bin_next - gray2bin(sq_rptr), modulo 2**(ADDR_W+1).
- almost_full_wr <= (level_next >= AF_LEVEL).
- Invariant: full_wr == (level_wr == DEPTH).

Full release timing:
- Full deassertion is pessimistic: it follows a read with latency SYNC_STAGES+1 write clocks after rd_gptr_wr changes.
- A stale sq_rptr may only over-report level; it never under-reports.

Boundary cases:
- Write while full: dropped; wr_en_mem_wr=0; pointers unchanged; overflow event raised.
- Simultaneous accepted write and read-pointer change: level reflects both; net level may be unchanged.
- Pointer wrap: the Gray value goes from 1<<ADDR_W mirror back to 0 without a false full.
- Reset mid-operation while full: the next edge gives an empty state, level 0, full_wr=0.
- rd_gptr_wr is sampled without qualification; the read side guarantees only single-bit changes.

Optional Feature:
Macro FIFO_WR_OVF_STICKY_EN.
- Defined: overflow_wr sets on the first dropped write and stays 1 until wr_rst_wr.
- Undefined: overflow_wr is a one-cycle registered pulse, asserted in the cycle after each dropped write.
- Datapath and other status behave identically in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parametrised by width;
  - the DEPTH = 2**ADDR_W derivation;
  - the SYNC_STAGES minimum constant (2);
  - these are reused by the matching read-side controller.
- One sub-module: fifo_ptr_sync, a SYNC_STAGES-deep, width-parametrised flop chain with synchronous active-high reset.
  - It is instantiated here, and mirrored in the read domain.

Test Plan:
(ADDR_W=3, AF_LEVEL=6, SYNC_STAGES=2 unless noted)
1. Reset with wr_rst_wr=1 for 2 cycles, then release -> all outputs 0, wr_en_mem_wr follows wr_inc_wr.
2. rd_gptr_wr=0, 8 consecutive writes:
   - wr_addr_wr steps 0..7 then 0;
   - wr_ptr_wr steps 0,1,3,2,6,7,5,4,C;
   - almost_full_wr=1 after the 6th write edge;
   - full_wr=1 and level_wr=8 after the 8th edge.
3. Full, wr_inc_wr=1 for 2 cycles:
   - wr_en_mem_wr=0, pointers hold;
   - macro off: overflow_wr pulses 1 cycle per drop;
   - macro on: overflow_wr stays 1 until reset.
4. Full, rd_gptr_wr changes 0->1 -> full_wr falls and level_wr=7 exactly 3 cycles later; almost_full_wr stays 1.
5. Continuous writes with the read pointer tracking (level held 2..4) for 20 writes -> wr_ptr_wr wraps C->...->0, full_wr never asserts, wr_addr_wr wraps 7->0.
6. Assert wr_rst_wr for 1 cycle while full and overflowed -> next edge: level_wr=0, full_wr=0, overflow_wr=0, wr_ptr_wr=0, synchroniser flushed.
